// File: rtl/fp_arb_pkg.sv
// fp_arb_pkg: shared FSM state encodings and result constants for the FP unit arbiters
package fp_arb_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_UNIT_RST,
        S_SEND_A,
        S_SEND_B,
        S_WAIT_Z,
        S_RESPOND
    } state_t;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin select; req vector + last winner in, winner idx + found flag out
module rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] last,
    output logic [ID_W-1:0] idx,
    output logic            found
);
    logic [ID_W-1:0] j;
    always_comb begin
        idx = '0;
        j   = '0;
        // Walk from farthest to nearest so the lane right after last wins.
        for (int k = N; k >= 1; k--) begin
            j = ID_W'((int'(last) + k) % N);
            if (req[j]) idx = j;
        end
    end
    assign found = |req;
endmodule

// File: rtl/fp_unit_arbiter.sv
// fp_unit_arbiter: round-robin share of one strobe/ack FP unit; req_*/rsp_* per lane, unit_* to core, busy/timeout_err/grant_id status
module fp_unit_arbiter
    import fp_arb_pkg::*;
#(
    parameter int N       = 4,
    parameter int ID_W    = $clog2(N),
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [32*N-1:0]   req_a,
    input  logic [32*N-1:0]   req_b,
    input  logic [N-1:0]      req_stb,
    output logic [N-1:0]      req_ack,
    output logic [31:0]       rsp_z,
    output logic [N-1:0]      rsp_valid,
    input  logic [N-1:0]      rsp_ack,
    output logic              unit_rst,
    output logic [31:0]       unit_a,
    output logic [31:0]       unit_b,
    output logic              unit_a_stb,
    output logic              unit_b_stb,
    input  logic              unit_a_ack,
    input  logic              unit_b_ack,
    input  logic [31:0]       unit_z,
    input  logic              unit_z_stb,
    output logic              unit_z_ack,
    output logic              busy,
    output logic              timeout_err,
    output logic [ID_W-1:0]   grant_id
);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t          state_q, state_d;
    logic [ID_W-1:0] last_q, last_d, grant_id_q, grant_id_d, win;
    logic            win_found;
    logic [31:0]     a_q, a_d, b_q, b_d, rsp_z_q, rsp_z_d;
    logic [N-1:0]    req_ack_q, req_ack_d, rsp_valid_q, rsp_valid_d;
    logic            unit_rst_q, unit_rst_d, a_stb_q, a_stb_d, b_stb_q, b_stb_d;
    logic            z_ack_q, z_ack_d, busy_q, busy_d, timeout_err_q, timeout_err_d;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;

    rr_pick #(.N(N), .ID_W(ID_W)) u_pick (
        .req   (req_stb),
        .last  (last_q),
        .idx   (win),
        .found (win_found)
    );

    // Saturate so a stuck unit can never wrap the counter back below TIMEOUT.
    assign cnt_inc = (cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        grant_id_d    = grant_id_q;
        a_d           = a_q;
        b_d           = b_q;
        rsp_z_d       = rsp_z_q;
        rsp_valid_d   = rsp_valid_q;
        a_stb_d       = a_stb_q;
        b_stb_d       = b_stb_q;
        timeout_err_d = timeout_err_q;
        cnt_d         = cnt_q;
        req_ack_d     = '0;
        unit_rst_d    = 1'b0;
        z_ack_d       = 1'b0;
        case (state_q)
            S_IDLE: if (win_found) begin
                a_d            = req_a[{win, 5'd0} +: 32];
                b_d            = req_b[{win, 5'd0} +: 32];
                grant_id_d     = win;
                req_ack_d[win] = 1'b1;
                unit_rst_d     = 1'b1;
                state_d        = S_UNIT_RST;
            end
            S_UNIT_RST: begin
                a_stb_d = 1'b1;
                state_d = S_SEND_A;
            end
            S_SEND_A: if (unit_a_ack) begin
                a_stb_d = 1'b0;
                b_stb_d = 1'b1;
                state_d = S_SEND_B;
            end
            S_SEND_B: if (unit_b_ack) begin
                b_stb_d = 1'b0;
                cnt_d   = '0;
                state_d = S_WAIT_Z;
            end
            S_WAIT_Z: if (unit_z_stb) begin
                rsp_z_d                 = unit_z;
                z_ack_d                 = 1'b1;
                rsp_valid_d[grant_id_q] = 1'b1;
                state_d                 = S_RESPOND;
            end else begin
                cnt_d = cnt_inc;
                if (cnt_inc == CW'(TIMEOUT)) begin
                    rsp_z_d                 = QNAN;
                    timeout_err_d           = 1'b1;
                    unit_rst_d              = 1'b1;
                    rsp_valid_d[grant_id_q] = 1'b1;
                    state_d                 = S_RESPOND;
                end
            end
            S_RESPOND: if (rsp_ack[grant_id_q]) begin
                rsp_valid_d = '0;
                last_d      = grant_id_q;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            last_q        <= ID_W'(N - 1);
            grant_id_q    <= '0;
            a_q           <= '0;
            b_q           <= '0;
            rsp_z_q       <= '0;
            rsp_valid_q   <= '0;
            req_ack_q     <= '0;
            unit_rst_q    <= 1'b1;
            a_stb_q       <= 1'b0;
            b_stb_q       <= 1'b0;
            z_ack_q       <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            grant_id_q    <= grant_id_d;
            a_q           <= a_d;
            b_q           <= b_d;
            rsp_z_q       <= rsp_z_d;
            rsp_valid_q   <= rsp_valid_d;
            req_ack_q     <= req_ack_d;
            unit_rst_q    <= unit_rst_d;
            a_stb_q       <= a_stb_d;
            b_stb_q       <= b_stb_d;
            z_ack_q       <= z_ack_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            cnt_q         <= cnt_d;
        end
    end

    assign req_ack     = req_ack_q;
    assign rsp_z       = rsp_z_q;
    assign rsp_valid   = rsp_valid_q;
    assign unit_rst    = unit_rst_q;
    assign unit_a      = a_q;
    assign unit_b      = b_q;
    assign unit_a_stb  = a_stb_q;
    assign unit_b_stb  = b_stb_q;
    assign unit_z_ack  = z_ack_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;
    assign grant_id    = grant_id_q;
endmodule

// File: tb/tb_fp_unit_arbiter.sv
// tb_fp_unit_arbiter: directed self-checking bench with lane and FP unit models
module tb_fp_unit_arbiter;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [127:0] req_a, req_b;
    logic [3:0]   req_stb, req_ack, rsp_valid, rsp_ack;
    logic [31:0]  rsp_z, unit_a, unit_b, unit_z;
    logic         unit_rst, unit_a_stb, unit_b_stb, unit_a_ack, unit_b_ack;
    logic         unit_z_stb, unit_z_ack, busy, timeout_err;
    logic [1:0]   grant_id;

    int n_tests = 0, n_fail = 0;

    int          launch [4];
    int          a_delay, z_delay, rsp_delay;
    bit          z_en;
    logic [31:0] z_val;

    int          served [4];
    int          n_grants, n_rsp, n_bhs, cyc, t_ack;
    int          grant_log [64];
    logic [3:0]  rsp_id_log [64];
    logic [31:0] rsp_z_log [64];
    int          lat_log [64];
    logic [31:0] a_seen, b_seen;
    int          bad_stable, bad_zack, bad_oh, bad_ack, bad_order, n_urst_resp;

    always #5 clk = ~clk;

    fp_unit_arbiter #(.N(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .req_stb(req_stb),
        .req_ack(req_ack), .rsp_z(rsp_z), .rsp_valid(rsp_valid), .rsp_ack(rsp_ack),
        .unit_rst(unit_rst), .unit_a(unit_a), .unit_b(unit_b),
        .unit_a_stb(unit_a_stb), .unit_b_stb(unit_b_stb),
        .unit_a_ack(unit_a_ack), .unit_b_ack(unit_b_ack),
        .unit_z(unit_z), .unit_z_stb(unit_z_stb), .unit_z_ack(unit_z_ack),
        .busy(busy), .timeout_err(timeout_err), .grant_id(grant_id)
    );

    // Lane + FP unit model: drives all DUT handshake inputs on the falling edge.
    initial begin
        bit          pend, saw_urst, pa_stb, pa_ack, pb_stb, pb_ack, logged;
        logic [31:0] pa, pb, prz;
        logic [3:0]  prv, prack, pra;
        int          a_wait, zw, rw;
        req_stb = '0; rsp_ack = '0; unit_a_ack = 0; unit_b_ack = 0; unit_z_stb = 0; unit_z = '0;
        pend = 0; saw_urst = 0; pa_stb = 0; pa_ack = 0; pb_stb = 0; pb_ack = 0; logged = 0;
        pa = '0; pb = '0; prz = '0; prv = '0; prack = '0; pra = '0; a_wait = 0; zw = 0; rw = 0;
        n_grants = 0; n_rsp = 0; n_bhs = 0; cyc = 0; t_ack = 0; a_seen = '0; b_seen = '0;
        bad_stable = 0; bad_zack = 0; bad_oh = 0; bad_ack = 0; bad_order = 0; n_urst_resp = 0;
        for (int r = 0; r < 4; r++) served[r] = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (pa_stb && !pa_ack && (!unit_a_stb || unit_a != pa)) bad_stable++;
            if (pb_stb && !pb_ack && (!unit_b_stb || unit_b != pb)) bad_stable++;
            if (prv != 0 && prack == 0 && (rsp_valid != prv || rsp_z != prz)) bad_stable++;
            if (unit_z_ack && !unit_z_stb) bad_zack++;
            if (!$onehot0(rsp_valid)) bad_oh++;
            if (req_ack != 0 && (rsp_valid != 0 || !$onehot(req_ack) || req_ack == pra)) bad_ack++;
            if (unit_rst && rsp_valid != 0) n_urst_resp++;
            if (req_ack != 0) saw_urst = 0;
            if (unit_rst) saw_urst = 1;
            if (unit_a_stb && !pa_stb) begin
                if (!saw_urst) bad_order++;
                saw_urst = 0;
            end
            for (int r = 0; r < 4; r++) if (req_ack[r]) begin
                served[r]++;
                grant_log[n_grants] = r;
                n_grants++;
                t_ack = cyc;
            end
            unit_a_ack = 0;
            unit_b_ack = 0;
            if (rst || unit_rst) begin
                pend = 0; zw = 0; a_wait = 0; unit_z_stb = 0;
            end else begin
                if (unit_z_stb && unit_z_ack) begin
                    unit_z_stb = 0;
                    pend = 0;
                end else if (pend && z_en && !unit_z_stb) begin
                    zw++;
                    if (zw >= z_delay) begin
                        unit_z_stb = 1;
                        unit_z = z_val;
                    end
                end
                if (unit_a_stb) begin
                    if (a_wait >= a_delay) begin
                        unit_a_ack = 1;
                        a_seen = unit_a;
                    end else a_wait++;
                end else a_wait = 0;
                if (unit_b_stb && !pend) begin
                    unit_b_ack = 1;
                    b_seen = unit_b;
                    pend = 1;
                    zw = 0;
                    n_bhs++;
                end
            end
            if (rsp_valid != 0) begin
                if (!logged) begin
                    rsp_id_log[n_rsp] = rsp_valid;
                    rsp_z_log[n_rsp] = rsp_z;
                    lat_log[n_rsp] = cyc - t_ack;
                    n_rsp++;
                    logged = 1;
                end
                if (rw >= rsp_delay) rsp_ack = rsp_valid;
                else begin
                    rsp_ack = '0;
                    rw++;
                end
            end else begin
                rsp_ack = '0;
                rw = 0;
                logged = 0;
            end
            pa_stb = unit_a_stb; pa_ack = unit_a_ack; pa = unit_a;
            pb_stb = unit_b_stb; pb_ack = unit_b_ack; pb = unit_b;
            prv = rsp_valid; prack = rsp_ack; prz = rsp_z; pra = req_ack;
            for (int r = 0; r < 4; r++) req_stb[r] = (launch[r] != served[r]);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_rsp(input int n);
        int c = 0;
        while (n_rsp < n && c < 500) begin
            tick(1);
            c++;
        end
        check("rsp_wait", 32'(n_rsp >= n), 1);
    endtask

    task automatic wait_grant(input int n);
        int c = 0;
        while (n_grants < n && c < 500) begin
            tick(1);
            c++;
        end
        check("grant_wait", 32'(n_grants >= n), 1);
    endtask

    task automatic check_viol(input string tag);
        check({tag, "_stable"}, 32'(bad_stable), 0);
        check({tag, "_zack"}, 32'(bad_zack), 0);
        check({tag, "_onehot"}, 32'(bad_oh), 0);
        check({tag, "_reqack"}, 32'(bad_ack), 0);
        check({tag, "_rst_order"}, 32'(bad_order), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_unit_rst", 32'(unit_rst), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_req_ack", 32'(req_ack), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_z", rsp_z, 0);
        check("rst_a_stb", 32'(unit_a_stb), 0);
        check("rst_b_stb", 32'(unit_b_stb), 0);
        check("rst_z_ack", 32'(unit_z_ack), 0);
        check("rst_timeout_err", 32'(timeout_err), 0);
        check("rst_grant_id", 32'(grant_id), 0);
        tick(2);
        rst = 1'b0;
        tick(1);
        check("rst_unit_rst_drop", 32'(unit_rst), 0);
    endtask

    initial begin
        int g0, r0, u0;
        for (int r = 0; r < 4; r++) launch[r] = 0;
        req_a = '0; req_b = '0;
        a_delay = 0; z_delay = 5; rsp_delay = 0; z_en = 1; z_val = '0;
        #2;
        do_reset();

        // single request from lane 2: 2.0 * 3.0
        req_a[64 +: 32] = 32'h4000_0000;
        req_b[64 +: 32] = 32'h4040_0000;
        z_val = 32'h40C0_0000;
        launch[2]++;
        wait_rsp(1);
        check("single_grant", 32'(grant_log[0]), 2);
        check("single_rsp_id", 32'(rsp_id_log[0]), 32'b0100);
        check("single_rsp_z", rsp_z_log[0], 32'h40C0_0000);
        check("single_latency", 32'(lat_log[0]), 8);
        check("single_unit_a", a_seen, 32'h4000_0000);
        check("single_unit_b", b_seen, 32'h4040_0000);
        check("single_grant_id", 32'(grant_id), 2);
        tick(3);
        check("single_busy_low", 32'(busy), 0);
        check("single_rsp_clear", 32'(rsp_valid), 0);
        check_viol("single");

        // round-robin with all four lanes requesting continuously
        do_reset();
        for (int r = 0; r < 4; r++) begin
            req_a[32*r +: 32] = 32'h3F80_0000 + 32'(r);
            req_b[32*r +: 32] = 32'h4000_0000 + 32'(r);
        end
        z_val = 32'h3F80_0000;
        z_delay = 1;
        g0 = n_grants;
        r0 = n_rsp;
        for (int r = 0; r < 4; r++) launch[r] += 2;
        wait_rsp(r0 + 8);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("rr_grant%0d", k), 32'(grant_log[g0 + k]), 32'(k % 4));
            check($sformatf("rr_rsp_id%0d", k), 32'(rsp_id_log[r0 + k]), 32'(1) << (k % 4));
        end
        tick(3);
        check_viol("rr");

        // skip-ahead: last winner 1, then lanes 0 and 3 request together
        g0 = n_grants;
        r0 = n_rsp;
        launch[1]++;
        wait_grant(g0 + 1);
        launch[0]++;
        launch[3]++;
        wait_rsp(r0 + 3);
        check("skip_first", 32'(grant_log[g0]), 1);
        check("skip_second", 32'(grant_log[g0 + 1]), 3);
        check("skip_third", 32'(grant_log[g0 + 2]), 0);
        tick(3);

        // slow handshakes: A ack 3 cycles late, response ack 10 cycles late
        a_delay = 3;
        rsp_delay = 10;
        z_delay = 5;
        req_a[32 +: 32] = 32'h3FC0_0000;
        req_b[32 +: 32] = 32'h4000_0000;
        z_val = 32'h4040_0000;
        r0 = n_rsp;
        launch[1]++;
        wait_rsp(r0 + 1);
        check("slow_rsp_z", rsp_z_log[r0], 32'h4040_0000);
        check("slow_latency", 32'(lat_log[r0]), 11);
        check("slow_unit_a", a_seen, 32'h3FC0_0000);
        check("slow_unit_b", b_seen, 32'h4000_0000);
        tick(5);
        check("slow_rsp_held", 32'(rsp_valid), 32'b0010);
        check("slow_rsp_z_held", rsp_z, 32'h4040_0000);
        tick(10);
        check("slow_busy_low", 32'(busy), 0);
        check_viol("slow");
        a_delay = 0;
        rsp_delay = 0;

        // timeout: unit never answers
        z_en = 0;
        r0 = n_rsp;
        u0 = n_urst_resp;
        launch[2]++;
        wait_rsp(r0 + 1);
        check("to_rsp_z", rsp_z_log[r0], 32'h7FC0_0000);
        check("to_rsp_id", 32'(rsp_id_log[r0]), 32'b0100);
        check("to_latency", 32'(lat_log[r0]), 11);
        check("to_err", 32'(timeout_err), 1);
        check("to_unit_rst_pulse", 32'(n_urst_resp - u0), 1);
        tick(3);
        check("to_err_sticky", 32'(timeout_err), 1);
        check("to_busy_low", 32'(busy), 0);
        z_en = 1;
        z_val = 32'h40C0_0000;
        launch[0]++;
        wait_rsp(r0 + 2);
        check("to_next_rsp_z", rsp_z_log[r0 + 1], 32'h40C0_0000);
        check("to_next_rsp_id", 32'(rsp_id_log[r0 + 1]), 32'b0001);
        check("to_err_still", 32'(timeout_err), 1);
        tick(3);
        check_viol("timeout");

        // reset while waiting for Z
        z_delay = 50;
        u0 = n_bhs;
        launch[1]++;
        begin
            int c = 0;
            while (n_bhs <= u0 && c < 200) begin
                tick(1);
                c++;
            end
            check("midop_reach_wait", 32'(n_bhs > u0), 1);
        end
        tick(2);
        r0 = n_rsp;
        do_reset();
        tick(20);
        check("midop_no_rsp", 32'(n_rsp), 32'(r0));
        z_delay = 2;
        g0 = n_grants;
        launch[2]++;
        launch[0]++;
        wait_rsp(r0 + 2);
        check("midop_first_grant", 32'(grant_log[g0]), 0);
        check("midop_second_grant", 32'(grant_log[g0 + 1]), 2);
        tick(3);
        check_viol("midop");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
